// File: rtl/ce_strobe_pkg.sv
// Shared types and constants for the ce_strobe_gen trigger-to-strobe block.
package ce_strobe_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } fsm_state_t;

   localparam int SYNC_STAGES = 2;

   // Bitwise 2-of-3 majority used by the triple-redundant build.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/vote.sv
// Bitwise 2-of-3 majority voter; only built when CE_STROBE_TMR_EN is defined.
`ifdef CE_STROBE_TMR_EN
module vote
   import ce_strobe_pkg::*;
#(
   parameter int Width = 1
) (
   input  logic [Width-1:0] in_a,
   input  logic [Width-1:0] in_b,
   input  logic [Width-1:0] in_c,
   output logic [Width-1:0] voted
);

   // Majority per bit.
   always_comb begin
      voted = '0;
      for (int i = 0; i < Width; i++) begin
         voted[i] = maj3(in_a[i], in_b[i], in_c[i]);
      end
   end

endmodule
`endif

// File: rtl/ce_strobe_gen.sv
// Trigger level to programmable burst of single-cycle CE strobes.
// Define CE_STROBE_TMR_EN for the triple-redundant register build with voted state.
module ce_strobe_gen
   import ce_strobe_pkg::*;
#(
   parameter int PRESCALE_W = 8,
   parameter int BURST_W    = 4
) (
   input  logic                  CLK,
   input  logic                  RST_B,
   input  logic                  EN,
   input  logic                  TRIG_IN,
   input  logic [PRESCALE_W-1:0] PRESCALE,
   input  logic [BURST_W-1:0]    BURST_LEN,
   input  logic                  CLR_OVR,
   output logic                  CE,
   output logic                  BUSY,
   output logic                  OVERRUN
);

   typedef struct packed {
      fsm_state_t            state;
      logic                  cont;
      logic                  ce;
      logic                  busy;
      logic                  ovr;
      logic                  edge_ff;
      logic                  sync_last;
      logic [PRESCALE_W-1:0] pcnt;
      logic [PRESCALE_W-1:0] reload;
      logic [BURST_W-1:0]    bcnt;
   } regs_t;

   localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1);
   localparam logic [BURST_W-1:0]    BCNT_ONE = BURST_W'(1);

   logic [SYNC_STAGES-2:0] sync_front_r;
   regs_t                  cur_s;
   regs_t                  nxt_s;
   logic                   trig_pulse_s;

   // Front synchronizer stages; never triplicated.
   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         sync_front_r <= '0;
      end else begin
         sync_front_r[0] <= TRIG_IN;
         for (int i = 1; i < SYNC_STAGES - 1; i++) begin
            sync_front_r[i] <= sync_front_r[i-1];
         end
      end
   end

   // Next-state logic, always evaluated from the (voted) current state.
   always_comb begin
      nxt_s           = cur_s;
      trig_pulse_s    = cur_s.sync_last & ~cur_s.edge_ff;
      nxt_s.sync_last = sync_front_r[SYNC_STAGES-2];
      nxt_s.edge_ff   = cur_s.sync_last;
      nxt_s.ce        = 1'b0;

      // A set in the same cycle as a clear takes priority.
      if (trig_pulse_s && EN && (cur_s.state == ST_RUN)) begin
         nxt_s.ovr = 1'b1;
      end else if (CLR_OVR) begin
         nxt_s.ovr = 1'b0;
      end else begin
         nxt_s.ovr = cur_s.ovr;
      end

      case (cur_s.state)
         ST_IDLE: begin
            if (trig_pulse_s && EN) begin
               nxt_s.state  = ST_RUN;
               nxt_s.busy   = 1'b1;
               nxt_s.reload = PRESCALE;
               nxt_s.pcnt   = PRESCALE;
               nxt_s.bcnt   = BURST_LEN;
               nxt_s.cont   = (BURST_LEN == {BURST_W{1'b0}});
            end else begin
               nxt_s.busy = 1'b0;
            end
         end
         ST_RUN: begin
            if (!EN) begin
               nxt_s.state = ST_IDLE;
               nxt_s.busy  = 1'b0;
            end else if (cur_s.pcnt != {PRESCALE_W{1'b0}}) begin
               nxt_s.pcnt = cur_s.pcnt - PCNT_ONE;
            end else begin
               nxt_s.ce   = 1'b1;
               nxt_s.pcnt = cur_s.reload;
               if (!cur_s.cont && (cur_s.bcnt != {BURST_W{1'b0}})) begin
                  nxt_s.bcnt = cur_s.bcnt - BCNT_ONE;
               end else begin
                  nxt_s.bcnt = cur_s.bcnt;
               end
               // Final strobe of a counted burst: leave RUN on the same edge.
               if (!cur_s.cont && (cur_s.bcnt == BCNT_ONE)) begin
                  nxt_s.state = ST_IDLE;
                  nxt_s.busy  = 1'b0;
               end else begin
                  nxt_s.state = ST_RUN;
               end
            end
         end
         default: begin
            nxt_s.state = ST_IDLE;
            nxt_s.busy  = 1'b0;
         end
      endcase
   end

`ifdef CE_STROBE_TMR_EN
   (* syn_preserve = 1 *) regs_t copy_r [3];

   logic [6:0]            ctrl_v_s;
   logic [PRESCALE_W-1:0] pcnt_v_s;
   logic [PRESCALE_W-1:0] reload_v_s;
   logic [BURST_W-1:0]    bcnt_v_s;

   function automatic logic [6:0] ctrl_of(input regs_t r);
      return {r.state, r.cont, r.ce, r.busy, r.ovr, r.edge_ff, r.sync_last};
   endfunction

   // Three identical copies all load the same next state.
   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         for (int i = 0; i < 3; i++) begin
            copy_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            copy_r[i] <= nxt_s;
         end
      end
   end

   vote #(.Width(7)) u_vote_ctrl (
      .in_a (ctrl_of(copy_r[0])),
      .in_b (ctrl_of(copy_r[1])),
      .in_c (ctrl_of(copy_r[2])),
      .voted(ctrl_v_s)
   );

   vote #(.Width(PRESCALE_W)) u_vote_pcnt (
      .in_a (copy_r[0].pcnt),
      .in_b (copy_r[1].pcnt),
      .in_c (copy_r[2].pcnt),
      .voted(pcnt_v_s)
   );

   vote #(.Width(PRESCALE_W)) u_vote_reload (
      .in_a (copy_r[0].reload),
      .in_b (copy_r[1].reload),
      .in_c (copy_r[2].reload),
      .voted(reload_v_s)
   );

   vote #(.Width(BURST_W)) u_vote_bcnt (
      .in_a (copy_r[0].bcnt),
      .in_b (copy_r[1].bcnt),
      .in_c (copy_r[2].bcnt),
      .voted(bcnt_v_s)
   );

   // Reassemble the voted state for next-state logic and outputs.
   always_comb begin
      cur_s           = '0;
      cur_s.state     = fsm_state_t'(ctrl_v_s[6]);
      cur_s.cont      = ctrl_v_s[5];
      cur_s.ce        = ctrl_v_s[4];
      cur_s.busy      = ctrl_v_s[3];
      cur_s.ovr       = ctrl_v_s[2];
      cur_s.edge_ff   = ctrl_v_s[1];
      cur_s.sync_last = ctrl_v_s[0];
      cur_s.pcnt      = pcnt_v_s;
      cur_s.reload    = reload_v_s;
      cur_s.bcnt      = bcnt_v_s;
   end
`else
   regs_t state_r;

   // Single copy of all control state.
   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         state_r <= '0;
      end else begin
         state_r <= nxt_s;
      end
   end

   assign cur_s = state_r;
`endif

   assign CE      = cur_s.ce;
   assign BUSY    = cur_s.busy;
   assign OVERRUN = cur_s.ovr;

endmodule

// File: doc/ce_strobe_gen.md
# ce_strobe_gen

Upstream companion to the counter primitives. Converts an asynchronous trigger level into a programmable burst of single-cycle clock-enable strobes. The CE output drives a counter's CE input directly. Sits between front-end trigger/pulse sources and the event/rate counters in the control path.

## Interface
Parameters:
- PRESCALE_W, 8, width of the prescale (strobe spacing) field
- BURST_W, 4, width of the burst-length field

Ports:
- CLK  in  1  system clock; all state on rising edge
- RST_B  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset
- EN  in  1  block enable; synchronous to CLK
- TRIG_IN  in  1  trigger level, asynchronous to CLK
- PRESCALE  in  PRESCALE_W  strobe spacing P; strobes are P+1 cycles apart
- BURST_LEN  in  BURST_W  strobes per trigger; 0 = continuous
- CLR_OVR  in  1  synchronous clear of OVERRUN
- CE  out  1  single-cycle enable strobe, registered
- BUSY  out  1  high while a burst is in progress, registered
- OVERRUN  out  1  sticky flag; a trigger arrived while BUSY

## Operation
- TRIG_IN passes through a 2-FF synchronizer and a third FF for rising-edge detect. The resulting trig_pulse is one cycle wide. Level-held triggers produce one pulse only.
- FSM states: IDLE, RUN.
- IDLE -> RUN when trig_pulse & EN. On this transition:
  - PRESCALE latches into the reload register; pcnt = P.
  - BURST_LEN latches; bcnt = BURST_LEN.
  - cont = (BURST_LEN == 0).
- Behaviour each RUN cycle:
  - If pcnt != 0: pcnt decrements.
  - If pcnt == 0: CE is registered high, pcnt reloads with P, and bcnt decrements unless cont is set.
  - When the strobe being issued is the last one (bcnt == 1 and cont clear), the FSM returns to IDLE on the same edge.
- RUN -> IDLE when EN is low, regardless of counters. No CE is issued on that edge.
- PRESCALE and BURST_LEN changes during RUN have no effect until the next trigger.
- trig_pulse while in RUN: the pulse is ignored, the burst continues, and OVERRUN sets.
- trig_pulse while EN is low: ignored, with no OVERRUN.
- OVERRUN: CLR_OVR clears it. If a set and CLR_OVR occur in the same cycle, set wins.
- Arithmetic: counters are unsigned and wrap-free. pcnt is PRESCALE_W bits and bcnt is BURST_W bits. Decrement happens only when nonzero.

## Timing
- Reset values: CE=0, BUSY=0, OVERRUN=0, FSM=IDLE, pcnt=0, bcnt=0, synchronizer FFs=0. Reset mid-burst aborts immediately, with no further CE.
- Edge 0 is the first rising edge at which TRIG_IN is sampled high.
  - The FSM enters RUN, and BUSY goes high, at edge 2.
  - The first CE is high in the cycle following edge 3+P.
  - Later strobes come every P+1 edges.
- P=0 gives a CE every cycle, back-to-back.
- BUSY falls on the same edge that registers the final CE, so the last CE and BUSY=0 coincide.
- A new trigger is accepted when BUSY is low at the edge where trig_pulse is high. The minimum re-trigger gap is set only by the synchronizer.
- TRIG_IN must be high for at least 2 CLK periods and low for at least 2 CLK periods to be resolved reliably.

## Configuration
- CE_STROBE_TMR_EN defined:
  - FSM state, pcnt, bcnt, cont, the latched reload values, the CE/BUSY/OVERRUN registers and the edge-detect FF are each triplicated, with syn_preserve.
  - Next-state logic of all three copies is computed from the voted values, via the vote module (parameter Width).
  - Outputs are the voted values.
  - The synchronizer's first FF is not triplicated.
- CE_STROBE_TMR_EN undefined: single copy of every register, with no voters.
- Cycle-level behaviour is identical in both builds.

## Structure
- Shared package (ce_strobe_pkg):
  - FSM state encoding constants ST_IDLE=1'b0, ST_RUN=1'b1.
  - Synchronizer depth constant SYNC_STAGES=2.
- Sub-module: existing vote (Width parameter) instantiated per triplicated register group, in TMR build only.
- The synchronizer remains inline.

## Test plan
- Basic burst: P=3, BURST_LEN=4, 5-cycle TRIG_IN pulse -> 4 CE pulses 4 cycles apart. First CE after edge 6, last after edge 18. BUSY high from edge 2 until the last CE.
- Back-to-back: P=0, BURST_LEN=3 -> CE high for 3 consecutive cycles. BUSY drops with the third.
- Continuous and abort: BURST_LEN=0, P=1 -> CE every 2nd cycle while EN=1. Deassert EN -> no further CE, and BUSY=0 one edge later.
- Overrun: P=7, BURST_LEN=2, with a second trigger during RUN -> exactly 2 CE, OVERRUN=1. CLR_OVR pulse -> OVERRUN=0. Simultaneous set and clear -> OVERRUN=1.
- Reset mid-burst: assert RST_B low asynchronously during RUN -> CE, BUSY and OVERRUN are 0 immediately. After release, a new trigger produces a full burst.
- Held level and parameter change: TRIG_IN held high for 50 cycles -> one burst only. Changing PRESCALE mid-burst -> spacing stays unchanged until the next trigger. Repeat in the CE_STROBE_TMR_EN build and check identical waveforms.
